// File: rtl/uart_rx_framed.sv
// Framed UART receiver: configurable data width, parity and stop bits, majority-vote
// sampling, false-start rejection and parity/framing/break reporting.
module uart_rx_framed #(
  parameter int unsigned DIVISOR   = 1024,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxi,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(DIVISOR);
  localparam int unsigned BW = $clog2(DATA_BITS + 3);
  localparam int unsigned MID = DIVISOR / 2;

  localparam logic [CW-1:0] MID_M1   = CW'(MID - 1);
  localparam logic [CW-1:0] MID_C    = CW'(MID);
  localparam logic [CW-1:0] MID_P1   = CW'(MID + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIVISOR - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 meta_q, rs_q, rs_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 brk_q, brk_d;

  logic maj;
  logic at_mid_m1, at_mid, at_decide, at_end;

  // Synchroniser idles high so a reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q    <= 1'b1;
      rs_q      <= 1'b1;
      rs_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, so
      // the order of statements in a clocked block never changes the hardware.
      meta_q    <= rxi;
      rs_q      <= meta_q;
      rs_prev_q <= rs_q;
    end
  end

  assign at_mid_m1 = (cnt_q == MID_M1);
  assign at_mid    = (cnt_q == MID_C);
  assign at_decide = (cnt_q == MID_P1);
  assign at_end    = (cnt_q == LAST_CNT);

  // Vote of the samples at Mid-1 and Mid with the live value at Mid+1.
  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rs_q) | (samp_q[1] & rs_q);

  always_comb begin
    // NOTE: every output of this block is defaulted first; a path that leaves one
    // unassigned would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_out_d = 1'b0;
    ferr_out_d = 1'b0;
    brk_d      = 1'b0;

    if (state_q != S_IDLE && state_q != S_BREAK_WAIT) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
      if (at_mid_m1) samp_d[0] = rs_q;
      if (at_mid)    samp_d[1] = rs_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rs_prev_q && !rs_q) begin
          state_d   = S_START;
          cnt_d     = '0;
          bit_d     = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
          par_bit_d = 1'b0;
        end
      end

      S_START: begin
        if (at_decide && maj) begin
          state_d = S_IDLE;
        end else if (at_end) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (at_decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (at_decide) begin
          par_bit_d = maj;
          perr_d    = (PARITY == 1) ? ~(^shift_q ^ maj) : (^shift_q ^ maj);
        end
        if (at_end) state_d = S_STOP;
      end

      S_STOP: begin
        if (at_decide) begin
          if (bit_q == '0 && !maj && shift_q == '0 && !par_bit_q) begin
            brk_d   = 1'b1;
            state_d = S_BREAK_WAIT;
          end else if (bit_q == LAST_STOP) begin
            // Leave half a bit early so a back-to-back start edge is not missed.
            valid_d    = 1'b1;
            data_d     = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_q | ~maj;
            state_d    = S_IDLE;
          end else begin
            ferr_d = ferr_q | ~maj;
          end
        end else if (at_end) begin
          bit_d = bit_q + 1'b1;
        end
      end

      S_BREAK_WAIT: begin
        if (rs_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      samp_q     <= 2'b11;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      brk_q      <= brk_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign break_det  = brk_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: three configurations (8N1, 7E1, 8N2) driven
// with directed frames; a monitor pops expected characters on every valid strobe.
module tb_uart_rx_framed;

  localparam int DIV = 16;

  typedef struct {
    int         idx;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic v0, pe0, fe0, bk0, busy0;
  logic v1, pe1, fe1, bk1, busy1;
  logic v2, pe2, fe2, bk2, busy2;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   brk_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  uart_rx_framed #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rxi(rx0), .data(d0), .valid(v0),
    .parity_err(pe0), .frame_err(fe0), .break_det(bk0), .busy(busy0));

  uart_rx_framed #(.DIVISOR(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rxi(rx1), .data(d1), .valid(v1),
    .parity_err(pe1), .frame_err(fe1), .break_det(bk1), .busy(busy1));

  uart_rx_framed #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rxi(rx2), .data(d2), .valid(v2),
    .parity_err(pe2), .frame_err(fe2), .break_det(bk2), .busy(busy2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.idx = idx; e.d = d; e.pe = pe; e.fe = fe;
    exp_q.push_back(e);
  endtask

  task automatic mon(input int idx, input logic v, input logic [8:0] d,
                     input logic pe, input logic fe, input logic bk);
    exp_t e;
    if (bk) brk_cnt[idx]++;
    if (v) begin
      if (exp_q.size() == 0) begin
        check($sformatf("unexpected_valid_u%0d", idx), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("sb_inst_u%0d", idx), idx, e.idx);
        check($sformatf("sb_data_u%0d", idx), {23'd0, d}, {23'd0, e.d});
        check($sformatf("sb_parity_err_u%0d", idx), {31'd0, pe}, {31'd0, e.pe});
        check($sformatf("sb_frame_err_u%0d", idx), {31'd0, fe}, {31'd0, e.fe});
        check($sformatf("valid_with_break_u%0d", idx), {31'd0, bk}, 32'd0);
      end
    end else begin
      check($sformatf("flags_unqualified_u%0d", idx), {30'd0, pe, fe}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, v0, {1'b0, d0}, pe0, fe0, bk0);
      mon(1, v1, {2'b0, d1}, pe1, fe1, bk1);
      mon(2, v2, {1'b0, d2}, pe2, fe2, bk2);
    end
  end

  task automatic set_rx(input int idx, input logic b);
    case (idx)
      0: rx0 = b;
      1: rx1 = b;
      default: rx2 = b;
    endcase
  endtask

  // Drives n bits LSB first, one bit period each, changing on the falling clock edge.
  task automatic send_bits(input int idx, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(idx, bits[i]);
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {29'd0, v0, v1, v2}, 32'd0);
    check({tag, "_busy"}, {29'd0, busy0, busy1, busy2}, 32'd0);
    check({tag, "_flags"}, {26'd0, pe0, fe0, pe1, fe1, pe2, fe2}, 32'd0);
    check({tag, "_break"}, {29'd0, bk0, bk1, bk2}, 32'd0);
    check({tag, "_data_u0"}, {24'd0, d0}, 32'd0);
    check({tag, "_data_u1"}, {25'd0, d1}, 32'd0);
    check({tag, "_data_u2"}, {24'd0, d2}, 32'd0);
  endtask

  initial begin
    int   busy_seen;
    int   clear_cyc;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2 * DIV) @(negedge clk);

    // 8N1 stream of every byte value, back to back.
    for (int j = 0; j < 256; j++) begin
      b = j[7:0];
      push(0, {1'b0, b}, 1'b0, 1'b0);
      send_bits(0, {6'd0, 1'b1, b, 1'b0}, 10);
    end
    repeat (2 * DIV) @(negedge clk);

    // Short low glitch on idle line: start is rejected within one bit period.
    busy_seen = 0;
    clear_cyc = -1;
    for (int c = 0; c < 2 * DIV; c++) begin
      rx0 = (c < DIV / 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy0) busy_seen = 1;
      else if (busy_seen != 0 && clear_cyc < 0) clear_cyc = c;
    end
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_cleared_in_time", {31'd0, (clear_cyc >= 0 && clear_cyc < DIV)}, 32'd1);

    // Break: three frame times of low, then a normal frame.
    rx0 = 1'b0;
    repeat (3 * 10 * DIV) @(negedge clk);
    rx0 = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("break_count_after_break", brk_cnt[0], 1);
    push(0, 9'h03C, 1'b0, 1'b0);
    send_bits(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (2 * DIV) @(negedge clk);

    // 7E1: 0x55 has four ones, so even parity bit is 0.
    push(1, 9'h055, 1'b0, 1'b0);
    send_bits(1, {6'd0, 1'b1, 1'b0, 7'h55, 1'b0}, 10);
    push(1, 9'h055, 1'b1, 1'b0);
    send_bits(1, {6'd0, 1'b1, 1'b1, 7'h55, 1'b0}, 10);
    repeat (2 * DIV) @(negedge clk);

    // 8N2: good frame, then second stop bit low.
    push(2, 9'h05A, 1'b0, 1'b0);
    send_bits(2, {5'd0, 2'b11, 8'h5A, 1'b0}, 11);
    push(2, 9'h0A5, 1'b0, 1'b1);
    send_bits(2, {5'd0, 2'b01, 8'hA5, 1'b0}, 11);
    rx2 = 1'b1;
    repeat (2 * DIV) @(negedge clk);

    // Reset during data bit 4 of an 8N1 frame, then a clean 0x81.
    send_bits(0, {11'd0, 4'b0000, 1'b0}, 5);
    rx0 = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    push(0, 9'h081, 1'b0, 1'b0);
    send_bits(0, {6'd0, 1'b1, 8'h81, 1'b0}, 10);
    repeat (3 * DIV) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    check("break_count_u0", brk_cnt[0], 1);
    check("break_count_u1", brk_cnt[1], 0);
    check("break_count_u2", brk_cnt[2], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
Parametrised successor to the fixed 8N1 UART receiver. It adds configurable data width, optional parity, 1 or 2 stop bits, majority-vote bit sampling, false-start rejection, and parity, framing and break reporting. It sits between the external RX pin and the display-controller command parser. Each received character is presented as a one-cycle strobe with its error flags.

Parameters:
DIVISOR, 1024, clock cycles per bit period; must be >= 8.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset (0 = reset).
rxi  in  1  raw serial input; idles high; asynchronous to clk.
data  out  DATA_BITS  last received character, LSB = first bit received.
valid  out  1  one-cycle strobe: a frame completed; data and flags are valid this cycle.
parity_err  out  1  qualified by valid; parity mismatch; always 0 when PARITY=0.
frame_err  out  1  qualified by valid; a stop bit was sampled low.
break_det  out  1  one-cycle strobe: break condition detected.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Input path: 2-flop synchroniser on rxi, reset to 1. All decisions use the synchronised signal rs.
- Reset values while rst=0:
  - data=0, valid=0, parity_err=0, frame_err=0, break_det=0, busy=0.
  - state=IDLE; bit counter=0; shift register=0.
  - Deasserting rst mid-frame discards the frame; no strobe is produced.
- Timing: a cycle counter counts 0..DIVISOR-1 per bit period and restarts at the start edge. Mid = DIVISOR/2 (integer division).
- Sampling: each bit's value is the majority of rs at counts Mid-1, Mid and Mid+1.
- States:
  - IDLE: a falling edge on rs (1->0) moves to START with the counter cleared.
  - START: majority at Mid must be 0, otherwise it is a glitch: return to IDLE with no strobe. A valid start proceeds to DATA at the end of the bit period.
  - DATA: DATA_BITS bits shifted LSB first. Go to PARITY if PARITY!=0, otherwise to STOP.
  - PARITY: one bit. Odd mode requires XOR(data,p)=1; even mode requires XOR(data,p)=0.
  - STOP: STOP_BITS bit periods; every stop bit is checked.
    - Completion occurs at count Mid+1 of the last stop bit. That cycle: valid=1, data is updated, and parity_err and frame_err are set.
    - Return to IDLE on the same edge, so the receiver can resync on a start edge about half a bit early.
    - If any stop bit sampled 0, frame_err=1.
  - Break: all data bits 0, parity bit (if present) 0, and the first stop bit 0.
    - Pulse break_det instead of valid: valid stays 0, data is not updated.
    - Go to BREAK_WAIT, which remains until rs=1, then returns to IDLE.
- Flags: parity_err and frame_err are registered alongside valid and cleared on the next cycle, so they are 0 whenever valid=0.
- Latency: valid rises 2 synchroniser cycles plus (1 + DATA_BITS + P + STOP_BITS - 1)*DIVISOR + Mid + 1 cycles after the rxi falling edge, where P = 1 if PARITY!=0, otherwise 0.
- Continuous back-to-back frames, with a new start bit immediately after the stop bit, must be received with no loss.
- Counter width is $clog2(DIVISOR); the bit counter width is sized for DATA_BITS+3.

Test Plan:
- Config DIVISOR=16, 8N1: send all j=0..255, LSB first, back-to-back with no idle gap -> 256 valid strobes, data==j each time, no flags set.
- Config DATA_BITS=7, PARITY=2 (even): send 0x55 with correct parity 0 -> valid, data=0x55, parity_err=0. Resend 0x55 with parity bit 1 -> valid, parity_err=1.
- Config STOP_BITS=2: send 0xA5 with the second stop bit low -> valid, data=0xA5, frame_err=1, break_det=0.
- Glitch rejection: drive a low pulse of DIVISOR/4 cycles on idle rxi -> no valid, busy returns to 0 before DIVISOR cycles.
- Break: hold rxi=0 for 3 frame times, then release -> exactly one break_det pulse, no valid. A following 0x3C frame is received correctly.
- Reset mid-frame: assert rst=0 during data bit 4, release, then send 0x81 -> no strobe for the aborted frame, then valid with data=0x81.
